// File: rtl/pc_fetch_unit.sv
// pc_fetch_unit: program-counter stage of the single-cycle RISC-V core.
//
// Resolves branches and jumps from the control unit's br_op, the register
// file operands and the ALU result. Registers the next PC and owns the core
// run state (RUN / HALT / TRAP). Also counts retired instructions.
//
// Ports:
//   clk, rst      - core clock; synchronous active-high reset
//   run_en        - global step enable; low freezes all state
//   resume        - one-cycle pulse that leaves HALT
//   br_op[4:0]    - branch/jump/system code from the control unit
//   rs1_data      - register-file read port 1
//   rs2_data      - register-file read port 2
//   alu_res       - ALU result, used as the branch/jump target
//   pc            - current PC (registered)
//   pc_plus4      - pc + 4; link value for JAL/JALR (combinational)
//   branch_taken  - a control transfer is selected this cycle (combinational)
//   halted        - high while in HALT
//   trapped       - high while in TRAP
//   trap_pc       - PC of the faulting instruction; valid while trapped
//   instret       - retired-instruction count
//
// Handshake: there is no valid/ready pairing here. An instruction is consumed
// on every rising edge where run_en is high and the state is RUN. HALT
// consumes only the resume pulse. TRAP consumes nothing until reset.
module pc_fetch_unit #(
  parameter int              XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            run_en,
  input  logic            resume,
  input  logic [4:0]      br_op,
  input  logic [XLEN-1:0] rs1_data,
  input  logic [XLEN-1:0] rs2_data,
  input  logic [XLEN-1:0] alu_res,
  output logic [XLEN-1:0] pc,
  output logic [XLEN-1:0] pc_plus4,
  output logic            branch_taken,
  output logic            halted,
  output logic            trapped,
  output logic [XLEN-1:0] trap_pc,
  output logic [XLEN-1:0] instret
);

  localparam logic [4:0] OP_BEQ    = 5'b01000;
  localparam logic [4:0] OP_BNE    = 5'b01001;
  localparam logic [4:0] OP_BLT    = 5'b01100;
  localparam logic [4:0] OP_BGE    = 5'b01101;
  localparam logic [4:0] OP_BLTU   = 5'b01110;
  localparam logic [4:0] OP_BGEU   = 5'b01111;
  localparam logic [4:0] OP_JAL    = 5'b10000;
  localparam logic [4:0] OP_JALR   = 5'b10001;
  localparam logic [4:0] OP_EBREAK = 5'b11000;

  typedef enum logic [1:0] {
    ST_RUN  = 2'd0,
    ST_HALT = 2'd1,
    ST_TRAP = 2'd2
  } state_t;

  state_t          state, state_n;
  logic [XLEN-1:0] pc_n, instret_n, trap_pc_n;
  logic            decode_taken;
  logic [XLEN-1:0] target;
  logic            misaligned;

  assign pc_plus4 = pc + XLEN'(4);
  assign halted   = (state == ST_HALT);
  assign trapped  = (state == ST_TRAP);

  // Branch condition decode. The codes 01010 and 01011, the 00xxx group, and
  // every unlisted code fall through to "not taken", which means sequential.
  always_comb begin
    decode_taken = 1'b0;
    case (br_op)
      OP_BEQ:  decode_taken = (rs1_data == rs2_data);
      OP_BNE:  decode_taken = (rs1_data != rs2_data);
      OP_BLT:  decode_taken = ($signed(rs1_data) <  $signed(rs2_data));
      OP_BGE:  decode_taken = ($signed(rs1_data) >= $signed(rs2_data));
      OP_BLTU: decode_taken = (rs1_data <  rs2_data);
      OP_BGEU: decode_taken = (rs1_data >= rs2_data);
      OP_JAL,
      OP_JALR: decode_taken = 1'b1;
      default: decode_taken = 1'b0;
    endcase
  end

  // JALR drops bit 0 of the target. A misaligned target is detected only
  // after that masking, so JALR traps only when bit 1 is set.
  assign target       = (br_op == OP_JALR) ? {alu_res[XLEN-1:1], 1'b0} : alu_res;
  assign branch_taken = (state == ST_RUN) && decode_taken;
  assign misaligned   = branch_taken && (target[1:0] != 2'b00);

  always_comb begin
    state_n   = state;
    pc_n      = pc;
    instret_n = instret;
    trap_pc_n = trap_pc;
    if (run_en) begin
      case (state)
        ST_RUN: begin
          if (misaligned) begin
            // The faulting instruction does not retire. The PC stays on it.
            state_n   = ST_TRAP;
            trap_pc_n = pc;
          end else if (br_op == OP_EBREAK) begin
            // EBREAK retires, but the PC keeps pointing at it until resume.
            state_n   = ST_HALT;
            instret_n = instret + XLEN'(1);
          end else begin
            pc_n      = branch_taken ? target : pc_plus4;
            instret_n = instret + XLEN'(1);
          end
        end
        ST_HALT: begin
          if (resume) begin
            state_n = ST_RUN;
            pc_n    = pc_plus4;
          end
        end
        ST_TRAP: begin
          state_n = ST_TRAP;
        end
        default: begin
          state_n = ST_TRAP;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= ST_RUN;
      pc      <= RESET_PC;
      instret <= '0;
      trap_pc <= '0;
    end else begin
      state   <= state_n;
      pc      <= pc_n;
      instret <= instret_n;
      trap_pc <= trap_pc_n;
    end
  end

endmodule

// File: tb/tb_pc_fetch_unit.sv
module tb_pc_fetch_unit;

  localparam logic [4:0] OP_SEQ  = 5'b00000;
  localparam logic [4:0] OP_BEQ  = 5'b01000;
  localparam logic [4:0] OP_BNE  = 5'b01001;
  localparam logic [4:0] OP_NT   = 5'b01010;
  localparam logic [4:0] OP_BLT  = 5'b01100;
  localparam logic [4:0] OP_BGE  = 5'b01101;
  localparam logic [4:0] OP_BLTU = 5'b01110;
  localparam logic [4:0] OP_BGEU = 5'b01111;
  localparam logic [4:0] OP_JAL  = 5'b10000;
  localparam logic [4:0] OP_JALR = 5'b10001;
  localparam logic [4:0] OP_EBRK = 5'b11000;

  // ---------------- clock / reset ----------------
  logic        clk = 1'b0;
  logic        rst, run_en, resume;
  logic [4:0]  br_op;
  logic [31:0] rs1_data, rs2_data, alu_res;
  logic [31:0] pc, pc_plus4, trap_pc, instret;
  logic        branch_taken, halted, trapped;

  always #5 clk = ~clk;

  pc_fetch_unit dut (
    .clk(clk), .rst(rst), .run_en(run_en), .resume(resume), .br_op(br_op),
    .rs1_data(rs1_data), .rs2_data(rs2_data), .alu_res(alu_res),
    .pc(pc), .pc_plus4(pc_plus4), .branch_taken(branch_taken),
    .halted(halted), .trapped(trapped), .trap_pc(trap_pc), .instret(instret)
  );

  // ---------------- checking ----------------
  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, want %h", name, act, exp);
    end
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic        rst, run_en, resume;
    logic [4:0]  op;
    logic [31:0] rs1, rs2, alu;
    logic        e_taken;
    logic [31:0] e_pc;
    logic        e_halted, e_trapped;
    logic [31:0] e_trap_pc, e_instret;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic r, input logic en, input logic res, input logic [4:0] op,
                     input logic [31:0] a, input logic [31:0] b, input logic [31:0] alu,
                     input logic t, input logic [31:0] epc, input logic h, input logic tr,
                     input logic [31:0] tpc, input logic [31:0] inst);
    vec_t v;
    v.rst = r; v.run_en = en; v.resume = res; v.op = op;
    v.rs1 = a; v.rs2 = b; v.alu = alu;
    v.e_taken = t; v.e_pc = epc; v.e_halted = h; v.e_trapped = tr;
    v.e_trap_pc = tpc; v.e_instret = inst;
    vecs.push_back(v);
  endtask

  // ---------------- driver ----------------
  // Inputs are driven 1 time unit after a rising edge. Combinational outputs
  // are sampled 1 unit later, and registered outputs 1 unit after the next edge.
  task automatic drive(input logic r, input logic en, input logic res, input logic [4:0] op,
                       input logic [31:0] a, input logic [31:0] b, input logic [31:0] alu);
    rst = r; run_en = en; resume = res; br_op = op;
    rs1_data = a; rs2_data = b; alu_res = alu;
    #1;
  endtask

  task automatic next_edge();
    @(posedge clk);
    #1;
  endtask

  // ---------------- reference model ----------------
  // The model's run state is kept as a plain integer: 0 run, 1 halt, 2 trap.
  logic [31:0] m_pc, m_instret, m_trap_pc;
  int          m_mode;
  logic [31:0] exp_q[$];

  function automatic logic cond_holds(input logic [4:0] op, input logic [31:0] a,
                                      input logic [31:0] b);
    int signed sa, sb;
    sa = a; sb = b;
    case (op)
      OP_BEQ:  return a == b;
      OP_BNE:  return a != b;
      OP_BLT:  return sa < sb;
      OP_BGE:  return sa >= sb;
      OP_BLTU: return a < b;
      OP_BGEU: return a >= b;
      OP_JAL, OP_JALR: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  task automatic model_step(input logic r, input logic en, input logic res,
                            input logic [4:0] op, input logic [31:0] a,
                            input logic [31:0] b, input logic [31:0] alu);
    logic [31:0] tgt;
    logic        tk;
    tk  = (m_mode == 0) && cond_holds(op, a, b);
    tgt = (op == OP_JALR) ? (alu & 32'hFFFF_FFFE) : alu;
    if (r) begin
      m_pc = 0; m_mode = 0; m_instret = 0; m_trap_pc = 0;
    end else if (en) begin
      if (m_mode == 0) begin
        if (tk && (tgt % 4 != 0)) begin
          m_mode = 2; m_trap_pc = m_pc;
        end else if (op == OP_EBRK) begin
          m_mode = 1; m_instret = m_instret + 1;
        end else begin
          m_pc = tk ? tgt : m_pc + 4;
          m_instret = m_instret + 1;
        end
      end else if (m_mode == 1 && res) begin
        m_mode = 0; m_pc = m_pc + 4;
      end
    end
  endtask

  logic [4:0]  op_pool[14] = '{5'b00000, 5'b00101, 5'b01000, 5'b01001, 5'b01010, 5'b01011,
                               5'b01100, 5'b01101, 5'b01110, 5'b01111, 5'b10000,
                               5'b10001, 5'b11000, 5'b10100};
  logic [31:0] val_pool[6] = '{32'h0, 32'h1, 32'h5, 32'hFFFF_FFFF, 32'h8000_0000, 32'h7FFF_FFFF};

  function automatic logic [31:0] rand_val();
    if ($urandom_range(0, 3) == 0) return $urandom;
    return val_pool[$urandom_range(0, 5)];
  endfunction

  // ---------------- test ----------------
  initial begin
    // Test plan sequence. Each row is one cycle: the inputs, the expected
    // branch_taken in that cycle, and the expected registered state after the edge.
    //  rst en res op       rs1            rs2            alu            tk pc             h  t  trap_pc instret
    add(0, 1, 0, OP_SEQ,  0, 0, 0,                                        0, 32'h4,          0, 0, 0, 1);
    add(0, 1, 0, OP_SEQ,  0, 0, 0,                                        0, 32'h8,          0, 0, 0, 2);
    add(0, 1, 0, OP_SEQ,  0, 0, 0,                                        0, 32'hC,          0, 0, 0, 3);
    add(0, 1, 0, OP_SEQ,  0, 0, 0,                                        0, 32'h10,         0, 0, 0, 4);
    add(0, 1, 0, OP_BEQ,  5, 5, 32'h40,                                   1, 32'h40,         0, 0, 0, 5);
    add(0, 1, 0, OP_JAL,  0, 0, 32'h10,                                   1, 32'h10,         0, 0, 0, 6);
    add(0, 1, 0, OP_BEQ,  5, 6, 32'h40,                                   0, 32'h14,         0, 0, 0, 7);
    add(0, 1, 0, OP_BLT,  32'hFFFF_FFFF, 1, 32'h80,                       1, 32'h80,         0, 0, 0, 8);
    add(0, 1, 0, OP_BLTU, 32'hFFFF_FFFF, 1, 32'h200,                      0, 32'h84,         0, 0, 0, 9);
    add(0, 1, 0, OP_BNE,  3, 3, 32'h3,                                    0, 32'h88,         0, 0, 0, 10);
    add(0, 1, 0, OP_BGE,  1, 32'hFFFF_FFFF, 32'h20,                       1, 32'h20,         0, 0, 0, 11);
    add(0, 1, 0, OP_JALR, 0, 0, 32'h101,                                  1, 32'h100,        0, 0, 0, 12);
    add(0, 1, 0, OP_BGEU, 1, 32'hFFFF_FFFF, 32'h500,                      0, 32'h104,        0, 0, 0, 13);
    add(0, 1, 0, OP_NT,   7, 7, 32'h600,                                  0, 32'h108,        0, 0, 0, 14);
    add(0, 1, 0, OP_JAL,  0, 0, 32'h30,                                   1, 32'h30,         0, 0, 0, 15);
    add(0, 1, 0, OP_EBRK, 0, 0, 0,                                        0, 32'h30,         1, 0, 0, 16);
    for (int i = 0; i < 5; i++)
      add(0, 1, 0, OP_JAL, 0, 0, 32'h1000,                                0, 32'h30,         1, 0, 0, 16);
    add(0, 1, 1, OP_SEQ,  0, 0, 0,                                        0, 32'h34,         0, 0, 0, 16);
    add(0, 0, 0, OP_JAL,  0, 0, 32'h80,                                   1, 32'h34,         0, 0, 0, 16);
    for (int i = 0; i < 3; i++)
      add(0, 0, 0, OP_SEQ, 0, 0, 0,                                       0, 32'h34,         0, 0, 0, 16);
    add(0, 1, 0, OP_SEQ,  0, 0, 0,                                        0, 32'h38,         0, 0, 0, 17);
    add(0, 1, 0, OP_JAL,  0, 0, 32'hFFFF_FFFC,                            1, 32'hFFFF_FFFC,  0, 0, 0, 18);
    add(0, 1, 0, OP_SEQ,  0, 0, 0,                                        0, 32'h0,          0, 0, 0, 19);
    add(0, 1, 0, OP_EBRK, 0, 0, 0,                                        0, 32'h0,          1, 0, 0, 20);
    add(0, 0, 1, OP_SEQ,  0, 0, 0,                                        0, 32'h0,          1, 0, 0, 20);
    add(1, 1, 0, OP_SEQ,  0, 0, 0,                                        0, 32'h0,          0, 0, 0, 0);
    add(0, 1, 1, OP_SEQ,  0, 0, 0,                                        0, 32'h4,          0, 0, 0, 1);
    add(0, 1, 0, OP_JAL,  0, 0, 32'h20,                                   1, 32'h20,         0, 0, 0, 2);
    add(0, 1, 0, OP_JALR, 0, 0, 32'h102,                                  1, 32'h20,         0, 1, 32'h20, 2);
    add(0, 1, 1, OP_JAL,  0, 0, 32'h40,                                   0, 32'h20,         0, 1, 32'h20, 2);
    add(0, 0, 0, OP_SEQ,  0, 0, 0,                                        0, 32'h20,         0, 1, 32'h20, 2);
    add(1, 1, 0, OP_SEQ,  0, 0, 0,                                        0, 32'h0,          0, 0, 0, 0);
    add(0, 1, 0, OP_JAL,  0, 0, 32'h2,                                    1, 32'h0,          0, 1, 0, 0);
    add(1, 0, 0, OP_SEQ,  0, 0, 0,                                        0, 32'h0,          0, 0, 0, 0);

    // Reset with every other input idle, then check the reset state.
    rst = 1; run_en = 1; resume = 0; br_op = 0; rs1_data = 0; rs2_data = 0; alu_res = 0;
    repeat (2) @(posedge clk);
    #1;
    check("reset pc", pc, 32'h0);
    check("reset instret", instret, 32'h0);
    check("reset trap_pc", trap_pc, 32'h0);
    check("reset halted", {31'b0, halted}, 32'h0);
    check("reset trapped", {31'b0, trapped}, 32'h0);

    foreach (vecs[i]) begin
      drive(vecs[i].rst, vecs[i].run_en, vecs[i].resume, vecs[i].op,
            vecs[i].rs1, vecs[i].rs2, vecs[i].alu);
      check($sformatf("row%0d taken", i), {31'b0, branch_taken}, {31'b0, vecs[i].e_taken});
      next_edge();
      check($sformatf("row%0d pc", i), pc, vecs[i].e_pc);
      check($sformatf("row%0d halted", i), {31'b0, halted}, {31'b0, vecs[i].e_halted});
      check($sformatf("row%0d trapped", i), {31'b0, trapped}, {31'b0, vecs[i].e_trapped});
      check($sformatf("row%0d trap_pc", i), trap_pc, vecs[i].e_trap_pc);
      check($sformatf("row%0d instret", i), instret, vecs[i].e_instret);
    end

    // Hand sequence: a JAL with a misaligned target traps, and the trap holds
    // across several cycles with resume pulsing. A reset then clears it.
    drive(0, 1, 0, OP_JAL, 0, 0, 32'h7);
    next_edge();
    for (int k = 0; k < 3; k++) begin
      drive(0, 1, 1, OP_SEQ, 0, 0, 0);
      check("trap hold taken", {31'b0, branch_taken}, 32'h0);
      next_edge();
      check("trap hold pc", pc, 32'h0);
      check("trap hold trapped", {31'b0, trapped}, 32'h1);
    end
    drive(1, 1, 0, OP_SEQ, 0, 0, 0);
    next_edge();
    check("trap reset trapped", {31'b0, trapped}, 32'h0);

    // Randomized phase checked against the reference model. The reset
    // in the hand sequence above leaves the core in the reset state.
    m_pc = 0; m_mode = 0; m_instret = 0; m_trap_pc = 0;
    for (int n = 0; n < 3000; n++) begin
      logic        r_rst, r_en, r_res, m_tk;
      logic [4:0]  r_op;
      logic [31:0] r_a, r_b, r_alu;
      r_rst = ($urandom_range(0, 59) == 0);
      r_en  = ($urandom_range(0, 9) != 0);
      r_res = ($urandom_range(0, 4) == 0);
      r_op  = ($urandom_range(0, 7) == 0) ? 5'($urandom) : op_pool[$urandom_range(0, 13)];
      r_a   = rand_val();
      r_b   = ($urandom_range(0, 2) == 0) ? r_a : rand_val();
      r_alu = $urandom;
      if ($urandom_range(0, 3) != 0) r_alu = r_alu & 32'hFFFF_FFFC;
      drive(r_rst, r_en, r_res, r_op, r_a, r_b, r_alu);
      m_tk = (m_mode == 0) && cond_holds(r_op, r_a, r_b);
      check("rand taken", {31'b0, branch_taken}, {31'b0, m_tk});
      check("rand pc_plus4", pc_plus4, m_pc + 32'd4);
      model_step(r_rst, r_en, r_res, r_op, r_a, r_b, r_alu);
      exp_q.push_back(m_pc);
      next_edge();
      check("rand pc", pc, exp_q.pop_front());
      check("rand instret", instret, m_instret);
      check("rand trap_pc", trap_pc, m_trap_pc);
      check("rand halted", {31'b0, halted}, {31'b0, m_mode == 1});
      check("rand trapped", {31'b0, trapped}, {31'b0, m_mode == 2});
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
